// File: rtl/flow_stats_pkg.sv
// Shared types and counter arithmetic for the per-flow statistics store.
// FLOW_STATS_SATURATE_EN selects saturating counters instead of wrapping ones.
package flow_stats_pkg;

    // Struct field widths follow these; top-level parameters must keep the same values.
    localparam int unsigned FS_ADDR_WIDTH = 10;
    localparam int unsigned FS_NUM_CNT    = 2;
    localparam int unsigned FS_CNT_WIDTH  = 64;
    localparam int unsigned FS_INC_WIDTH  = 16;

    typedef enum logic [1:0] {
        OP_UPD,
        OP_READ,
        OP_CLEAR
    } op_kind_e;

    typedef struct packed {
        logic                               valid;
        op_kind_e                           kind;
        logic [FS_ADDR_WIDTH-1:0]           addr;
        logic [FS_NUM_CNT*FS_INC_WIDTH-1:0] inc;
    } stage_t;

    function automatic logic [FS_CNT_WIDTH-1:0] add_cnt(
        input logic [FS_CNT_WIDTH-1:0] old,
        input logic [FS_INC_WIDTH-1:0] inc
    );
`ifdef FLOW_STATS_SATURATE_EN
        logic [FS_CNT_WIDTH:0] sum;
        sum = {1'b0, old} + {{(FS_CNT_WIDTH + 1 - FS_INC_WIDTH){1'b0}}, inc};
        return sum[FS_CNT_WIDTH] ? '1 : sum[FS_CNT_WIDTH-1:0];
`else
        return old + {{(FS_CNT_WIDTH - FS_INC_WIDTH){1'b0}}, inc};
`endif
    endfunction

endpackage

// File: rtl/flow_stats_ram.sv
// Simple dual-port, single-clock, read-first RAM with 1-cycle read latency.
module flow_stats_ram #(
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned DataWidth = 128
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  logic [DataWidth-1:0] wdata,
    input  logic [AddrWidth-1:0] raddr,
    output logic [DataWidth-1:0] rdata
);

    logic [DataWidth-1:0] mem [2**AddrWidth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/flow_stats_counters.sv
// Per-flow multi-counter store: pipelined read-modify-write with forwarding, management read
// with optional clear, and a zeroing sweep after reset. FLOW_STATS_SATURATE_EN: see package.
module flow_stats_counters
    import flow_stats_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH = FS_ADDR_WIDTH,
    parameter int unsigned C_NUM_CNT    = FS_NUM_CNT,
    parameter int unsigned C_CNT_WIDTH  = FS_CNT_WIDTH,
    parameter int unsigned C_INC_WIDTH  = FS_INC_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             upd_valid,
    output logic                             upd_ready,
    input  logic [C_ADDR_WIDTH-1:0]          upd_addr,
    input  logic [C_NUM_CNT*C_INC_WIDTH-1:0] upd_inc,
    input  logic                             mgmt_req,
    input  logic [C_ADDR_WIDTH-1:0]          mgmt_addr,
    input  logic                             mgmt_clear,
    output logic                             mgmt_ack,
    output logic [C_NUM_CNT*C_CNT_WIDTH-1:0] mgmt_data,
    output logic                             init_busy
);

    localparam int unsigned DataWidth = C_NUM_CNT * C_CNT_WIDTH;
    localparam logic [C_ADDR_WIDTH-1:0] LastAddr = '1;

    logic                    init_busy_q;
    logic [C_ADDR_WIDTH-1:0] init_cnt_q;
    logic                    can_accept, mgmt_acc, upd_acc;
    stage_t                  s1_d, s1_q;

    logic                    s2_valid_q;
    op_kind_e                s2_kind_q;
    logic [C_ADDR_WIDTH-1:0] s2_addr_q;
    logic [DataWidth-1:0]    s2_new_q;

    logic                    wp_valid_q;
    logic [C_ADDR_WIDTH-1:0] wp_addr_q;
    logic [DataWidth-1:0]    wp_data_q;

    logic                    ram_we;
    logic [C_ADDR_WIDTH-1:0] ram_waddr;
    logic [DataWidth-1:0]    ram_wdata, ram_rdata;
    logic [DataWidth-1:0]    old_val, new_val;

    logic                    mgmt_ack_q;
    logic [DataWidth-1:0]    mgmt_data_q;

    always_comb begin
        can_accept = reset && !init_busy_q;
        mgmt_acc   = can_accept && mgmt_req;
        upd_ready  = can_accept && !mgmt_req;
        upd_acc    = upd_ready && upd_valid;
        s1_d       = '0;
        s1_d.valid = mgmt_acc || upd_acc;
        s1_d.kind  = mgmt_acc ? (mgmt_clear ? OP_CLEAR : OP_READ) : OP_UPD;
        s1_d.addr  = mgmt_acc ? mgmt_addr : upd_addr;
        s1_d.inc   = upd_inc;
    end

    // Read-first RAM misses the write in flight and the one just committed; forward both.
    always_comb begin
        old_val = ram_rdata;
        if (s2_valid_q && s2_kind_q != OP_READ && s2_addr_q == s1_q.addr) begin
            old_val = s2_new_q;
        end else if (wp_valid_q && wp_addr_q == s1_q.addr) begin
            old_val = wp_data_q;
        end
    end

    always_comb begin
        new_val = old_val;
        case (s1_q.kind)
            OP_UPD: begin
                for (int k = 0; k < C_NUM_CNT; k++) begin
                    new_val[k*C_CNT_WIDTH +: C_CNT_WIDTH] =
                        add_cnt(old_val[k*C_CNT_WIDTH +: C_CNT_WIDTH],
                                s1_q.inc[k*C_INC_WIDTH +: C_INC_WIDTH]);
                end
            end
            OP_CLEAR: new_val = '0;
            default:  ;
        endcase
    end

    always_comb begin
        ram_we    = reset && (init_busy_q || (s2_valid_q && s2_kind_q != OP_READ));
        ram_waddr = init_busy_q ? init_cnt_q : s2_addr_q;
        ram_wdata = init_busy_q ? '0 : s2_new_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            init_busy_q <= 1'b1;
            init_cnt_q  <= '0;
            s1_q        <= '0;
            s2_valid_q  <= 1'b0;
            wp_valid_q  <= 1'b0;
            mgmt_ack_q  <= 1'b0;
            mgmt_data_q <= '0;
        end else begin
            if (init_busy_q) begin
                init_cnt_q <= init_cnt_q + 1'b1;
                if (init_cnt_q == LastAddr) begin
                    init_busy_q <= 1'b0;
                end
            end
            s1_q       <= s1_d;
            s2_valid_q <= s1_q.valid;
            wp_valid_q <= ram_we;
            mgmt_ack_q <= s1_q.valid && s1_q.kind != OP_UPD;
            if (s1_q.valid && s1_q.kind != OP_UPD) begin
                mgmt_data_q <= old_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        s2_kind_q <= s1_q.kind;
        s2_addr_q <= s1_q.addr;
        s2_new_q  <= new_val;
        wp_addr_q <= ram_waddr;
        wp_data_q <= ram_wdata;
    end

    assign mgmt_ack  = mgmt_ack_q;
    assign mgmt_data = mgmt_data_q;
    assign init_busy = init_busy_q;

    flow_stats_ram #(
        .AddrWidth(C_ADDR_WIDTH),
        .DataWidth(DataWidth)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(s1_d.addr),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_flow_stats_counters.sv
// Directed bench for flow_stats_counters with a per-address counter model and a cycle checker.
module tb_flow_stats_counters;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         upd_valid = 1'b0;
    logic         upd_ready;
    logic [9:0]   upd_addr = '0;
    logic [31:0]  upd_inc = '0;
    logic         mgmt_req = 1'b0;
    logic [9:0]   mgmt_addr = '0;
    logic         mgmt_clear = 1'b0;
    logic         mgmt_ack;
    logic [127:0] mgmt_data;
    logic         init_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flow_stats_counters dut (
        .clk       (clk),
        .reset     (reset),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_addr  (upd_addr),
        .upd_inc   (upd_inc),
        .mgmt_req  (mgmt_req),
        .mgmt_addr (mgmt_addr),
        .mgmt_clear(mgmt_clear),
        .mgmt_ack  (mgmt_ack),
        .mgmt_data (mgmt_data),
        .init_busy (init_busy)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_data(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [127:0] mdl [1024];
    int           sweep_left = 0;
    logic         started = 1'b0;
    logic         pend_ack = 1'b0, exp_ack = 1'b0;
    logic [127:0] pend_data = '0, exp_data = '0;

    function automatic logic [63:0] cnt_add(input logic [63:0] old, input logic [15:0] inc);
        logic [64:0] s;
        s = {1'b0, old} + {49'd0, inc};
`ifdef FLOW_STATS_SATURATE_EN
        if (s > 65'h0_FFFF_FFFF_FFFF_FFFF) return 64'hFFFF_FFFF_FFFF_FFFF;
`endif
        return s[63:0];
    endfunction

    initial forever begin
        @(posedge clk);
        if (!reset) begin
            started    = 1'b1;
            sweep_left = 1024;
            foreach (mdl[i]) mdl[i] = '0;
            pend_ack   = 1'b0;
            exp_ack    = 1'b0;
        end else begin
            exp_ack  = pend_ack;
            exp_data = pend_data;
            pend_ack = 1'b0;
            if (sweep_left != 0) begin
                sweep_left--;
            end else if (mgmt_req) begin
                pend_ack  = 1'b1;
                pend_data = mdl[mgmt_addr];
                if (mgmt_clear) mdl[mgmt_addr] = '0;
            end else if (upd_valid) begin
                mdl[upd_addr] = {cnt_add(mdl[upd_addr][127:64], upd_inc[31:16]),
                                 cnt_add(mdl[upd_addr][63:0], upd_inc[15:0])};
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (started) begin
            check1("init_busy", init_busy, sweep_left != 0);
            check1("upd_ready", upd_ready, reset && sweep_left == 0 && !mgmt_req);
            check1("mgmt_ack", mgmt_ack, exp_ack);
            if (exp_ack) check_data("mgmt_data_model", mgmt_data, exp_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [9:0] a, input logic [15:0] i0, input logic [15:0] i1);
        upd_valid = 1'b1;
        upd_addr  = a;
        upd_inc   = {i1, i0};
        step();
        upd_valid = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [9:0] a, input logic clr,
                               input logic [63:0] e0, input logic [63:0] e1);
        logic         got;
        logic [127:0] d;
        mgmt_req   = 1'b1;
        mgmt_addr  = a;
        mgmt_clear = clr;
        step();
        mgmt_req   = 1'b0;
        mgmt_clear = 1'b0;
        got = 1'b0;
        d   = '0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            if (mgmt_ack === 1'b1) begin
                got = 1'b1;
                d   = mgmt_data;
            end
        end
        check1({name, "_ack_seen"}, got, 1'b1);
        check_data(name, d, {e1, e0});
        step();
    endtask

    task automatic wait_sweep(input string name, output int n);
        n = 0;
        while (n < 1100) begin
            @(negedge clk);
            if (init_busy === 1'b1) n++;
            else break;
        end
        check1({name, "_done"}, init_busy, 1'b0);
        step();
    endtask

    int n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check1("reset_init_busy", init_busy, 1'b1);
        check1("reset_mgmt_ack", mgmt_ack, 1'b0);
        check_data("reset_mgmt_data", mgmt_data, '0);
        check1("reset_upd_ready", upd_ready, 1'b0);
        reset = 1'b1;

        wait_sweep("init_sweep", n);
        checks++;
        if (n != 1024) begin
            errors++;
            $display("FAIL init_busy_cycles: got %0d, expected 1024", n);
        end

        read_expect("zero_addr0", 10'd0, 1'b0, 64'd0, 64'd0);
        read_expect("zero_addr511", 10'd511, 1'b0, 64'd0, 64'd0);
        read_expect("zero_addr1023", 10'd1023, 1'b0, 64'd0, 64'd0);

        for (int i = 0; i < 4; i++) upd(10'd5, 16'd1, 16'd64);
        read_expect("burst_addr5", 10'd5, 1'b0, 64'd4, 64'd256);

        for (int i = 0; i < 4; i++) upd((i % 2 == 0) ? 10'd7 : 10'd9, 16'd1, 16'd100);
        read_expect("interleave_addr7", 10'd7, 1'b0, 64'd2, 64'd200);
        read_expect("interleave_addr9", 10'd9, 1'b0, 64'd2, 64'd200);

        // Clear-on-read followed by an update to the same address.
        mgmt_req   = 1'b1;
        mgmt_addr  = 10'd5;
        mgmt_clear = 1'b1;
        #1;
        check1("clear_cycle_upd_ready", upd_ready, 1'b0);
        step();
        mgmt_req   = 1'b0;
        mgmt_clear = 1'b0;
        upd_valid  = 1'b1;
        upd_addr   = 10'd5;
        upd_inc    = {16'd1, 16'd1};
        step();
        upd_valid = 1'b0;
        check1("clear_ack", mgmt_ack, 1'b1);
        check_data("clear_ack_data", mgmt_data, {64'd256, 64'd4});
        step();
        read_expect("after_clear_addr5", 10'd5, 1'b0, 64'd1, 64'd1);

        // Max address behaves like any other.
        upd(10'd1023, 16'hFFFF, 16'd3);
        read_expect("max_addr", 10'd1023, 1'b0, 64'h0000_0000_0000_FFFF, 64'd3);

        // Read without clear, then an update right behind it: read must not see it.
        mgmt_req  = 1'b1;
        mgmt_addr = 10'd9;
        step();
        mgmt_req = 1'b0;
        upd(10'd9, 16'd10, 16'd10);
        check1("read_then_upd_ack", mgmt_ack, 1'b1);
        check_data("read_then_upd_data", mgmt_data, {64'd200, 64'd2});
        step();
        read_expect("read_then_upd_later", 10'd9, 1'b0, 64'd12, 64'd210);

        // Near-overflow preload on an idle pipeline.
        repeat (3) step();
        dut.u_ram.mem[3] = {64'd0, 64'hFFFF_FFFF_FFFF_FFFE};
        mdl[3] = {64'd0, 64'hFFFF_FFFF_FFFF_FFFE};
        upd(10'd3, 16'd5, 16'd0);
`ifdef FLOW_STATS_SATURATE_EN
        read_expect("overflow_addr3", 10'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
`else
        read_expect("overflow_addr3", 10'd3, 1'b0, 64'd3, 64'd0);
`endif

        // Reset one cycle after an accepted update restarts the sweep.
        upd(10'd8, 16'd7, 16'd7);
        reset = 1'b0;
        step();
        step();
        check1("midrun_reset_busy", init_busy, 1'b1);
        reset = 1'b1;
        wait_sweep("restart_sweep", n);
        read_expect("after_reset_addr8", 10'd8, 1'b0, 64'd0, 64'd0);
        read_expect("after_reset_addr5", 10'd5, 1'b0, 64'd0, 64'd0);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
